// File: rtl/conv2d_wmem_if.sv
// rtl/conv2d_wmem_if.sv - result pixel stream and Avalon write-master bundle for conv2d_wmem
// Signals:
//   res_valid/res_data/res_ready     32-bit result pixel stream into the block
//   wmst_ctrl_*                       write-master control (base, length, go, done)
//   wmst_user_*                       write-master data buffer (push, data, full)
// Modports:
//   master  the conv2d_wmem side (consumes pixels, drives the write master)
//   slave   the environment side (produces pixels, acts as the write master)
interface conv2d_wmem_if #(
   parameter int AW = 30,
   parameter int DW = 128
);
   logic          res_valid;
   logic [31:0]   res_data;
   logic          res_ready;
   logic          wmst_ctrl_fixed_location;
   logic [AW-1:0] wmst_ctrl_write_base;
   logic [AW-1:0] wmst_ctrl_write_length;
   logic          wmst_ctrl_go;
   logic          wmst_ctrl_done;
   logic          wmst_user_write_buffer;
   logic [DW-1:0] wmst_user_buffer_data;
   logic          wmst_user_buffer_full;

   modport master (
      input  res_valid, res_data, wmst_ctrl_done, wmst_user_buffer_full,
      output res_ready, wmst_ctrl_fixed_location, wmst_ctrl_write_base,
             wmst_ctrl_write_length, wmst_ctrl_go, wmst_user_write_buffer,
             wmst_user_buffer_data
   );

   modport slave (
      output res_valid, res_data, wmst_ctrl_done, wmst_user_buffer_full,
      input  res_ready, wmst_ctrl_fixed_location, wmst_ctrl_write_base,
             wmst_ctrl_write_length, wmst_ctrl_go, wmst_user_write_buffer,
             wmst_user_buffer_data
   );
endinterface

// File: rtl/conv2d_wmem.sv
// rtl/conv2d_wmem.sv - packs 32-bit result pixels into 128-bit beats and writes them to SDRAM
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   param_ena           start; rising edge latches the parameters below
//   param_yaddr         byte base address of the result buffer (16-byte aligned)
//   param_length_out    number of 32-bit result pixels
//   busy                high from the start edge until done_pulse
//   done_pulse          one-cycle completion pulse
//   bus                 pixel stream in + Avalon write-master out (conv2d_wmem_if.master)
// DW must be 128 (four 32-bit lanes, first pixel in lane 0).
module conv2d_wmem #(
   parameter int AW     = 30,
   parameter int DW     = 128,
   parameter int FDEPTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          param_ena,
   input  logic [AW-1:0] param_yaddr,
   input  logic [17:0]   param_length_out,
   output logic          busy,
   output logic          done_pulse,
   conv2d_wmem_if.master bus
);
   localparam int PW = $clog2(FDEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(FDEPTH);
   localparam logic [PW:0] LAST_CNT = (PW+1)'(FDEPTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_STREAM, S_WAIT, S_FIN} state_t;
   state_t state;

   logic          ena_q, done_q, go_q;
   logic [AW-1:0] base_q, wlen_q;
   logic [17:0]   len_q, acc_cnt;
   logic [16:0]   beats_q, beat_cnt, beats_in;
   logic [DW-1:0] pack_q, pack_nxt, beat_q;
   logic          beat_vld;
   logic [DW-1:0] mem [FDEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [PW:0]   count;
   logic          rise, push, pop, push_fills, fifo_full, accept, last_pix, beat_end;

   assign rise      = param_ena & ~ena_q;
   assign beats_in  = {1'b0, param_length_out[17:2]} + {16'd0, |param_length_out[1:0]};
   assign fifo_full = (count == FULL_CNT);
   assign push      = beat_vld;
   assign pop       = (count != '0) & ~bus.wmst_user_buffer_full &
                      ((state == S_STREAM) | (state == S_WAIT));
   // A pending push that lands on the last free slot must stall the stream this cycle,
   // otherwise a beat completed next cycle would have nowhere to go.
   assign push_fills = push & ~pop & (count == LAST_CNT);

   assign bus.res_ready = (state == S_STREAM) & (acc_cnt < len_q) & ~fifo_full & ~push_fills;
   assign accept        = bus.res_valid & bus.res_ready;
   assign last_pix      = (acc_cnt == len_q - 18'd1);
   assign beat_end      = (acc_cnt[1:0] == 2'd3) | last_pix;

   always_comb begin
      pack_nxt = pack_q;
      pack_nxt[{acc_cnt[1:0], 5'd0} +: 32] = bus.res_data;
   end

   assign bus.wmst_ctrl_fixed_location = 1'b0;
   assign bus.wmst_ctrl_write_base     = base_q;
   assign bus.wmst_ctrl_write_length   = wlen_q;
   assign bus.wmst_ctrl_go             = go_q;
   assign bus.wmst_user_write_buffer   = pop;
   assign bus.wmst_user_buffer_data    = (count != '0) ? mem[rptr] : '0;

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= beat_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         ena_q      <= 1'b0;
         done_q     <= 1'b0;
         go_q       <= 1'b0;
         busy       <= 1'b0;
         done_pulse <= 1'b0;
         base_q     <= '0;
         wlen_q     <= '0;
         len_q      <= '0;
         beats_q    <= '0;
         acc_cnt    <= '0;
         beat_cnt   <= '0;
         pack_q     <= '0;
         beat_q     <= '0;
         beat_vld   <= 1'b0;
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
      end else begin
         ena_q      <= param_ena;
         done_q     <= bus.wmst_ctrl_done;
         go_q       <= 1'b0;
         done_pulse <= 1'b0;
         beat_vld   <= 1'b0;

         if (accept) begin
            acc_cnt <= acc_cnt + 18'd1;
            if (beat_end) begin
               // Unused lanes of a tail beat are still zero from the previous clear.
               beat_q   <= pack_nxt;
               beat_vld <= 1'b1;
               pack_q   <= '0;
            end else begin
               pack_q <= pack_nxt;
            end
         end

         if (push) begin
            wptr <= wptr + 1'b1;
            if (beat_cnt != '1) beat_cnt <= beat_cnt + 17'd1;
         end
         if (pop) rptr <= rptr + 1'b1;
         count <= count + (PW+1)'(push) - (PW+1)'(pop);

         case (state)
            S_IDLE: begin
               if (rise) begin
                  base_q   <= param_yaddr;
                  len_q    <= param_length_out;
                  beats_q  <= beats_in;
                  wlen_q   <= AW'({beats_in, 4'b0000});
                  acc_cnt  <= '0;
                  beat_cnt <= '0;
                  pack_q   <= '0;
                  busy     <= 1'b1;
                  state    <= S_ARM;
               end
            end
            S_ARM: begin
               if (len_q == '0) begin
                  busy       <= 1'b0;
                  done_pulse <= 1'b1;
                  state      <= S_FIN;
               end else begin
                  go_q  <= 1'b1;
                  state <= S_STREAM;
               end
            end
            S_STREAM: begin
               if ((acc_cnt == len_q) && (beat_cnt == beats_q) && !beat_vld && (count == '0))
                  state <= S_WAIT;
            end
            S_WAIT: begin
               // Done edges seen before this state are protocol errors and are dropped.
               if (bus.wmst_ctrl_done && !done_q) begin
                  busy       <= 1'b0;
                  done_pulse <= 1'b1;
                  state      <= S_FIN;
               end
            end
            S_FIN: begin
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
